// File: rtl/avalon_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single Avalon-MM master port, data-priority with a starvation guard.
// Optional waitrequest timeout abort is compiled in with `define AVALON_ARB_TIMEOUT_EN.
module avalon_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_I_BUS, S_D_BUS, S_RESP} state_t;

  state_t        r_state, w_next;
  logic          w_d_req, w_in_bus, w_grant_d, w_grant_i, w_fin, w_tmo;
  logic [SW-1:0] r_starve;
  logic          r_own_d;
  logic [31:0]   r_addr, r_wdata, r_i_rdata, r_d_rdata;
  logic          r_rd, r_wr, r_i_done, r_d_done, r_busy;

  assign w_d_req  = d_rd | d_wr;
  assign w_in_bus = (r_state == S_I_BUS) || (r_state == S_D_BUS);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_fin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data wins unless it has starved a waiting fetch for STARVE_MAX grants
        if (w_d_req && ((r_starve < STARVE_LIM) || !i_req)) begin
          w_next    = S_D_BUS;
          w_grant_d = 1'b1;
        end else if (i_req) begin
          w_next    = S_I_BUS;
          w_grant_i = 1'b1;
        end
      end
      S_I_BUS, S_D_BUS: begin
        if (!avm_waitrequest) begin
          w_next = S_RESP;
          w_fin  = 1'b1;
        end else if (w_tmo) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_own_d   <= 1'b0;
      r_starve  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_busy   <= (w_next != S_IDLE);
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_wr    <= d_wr;
        r_rd    <= ~d_wr;
        r_own_d <= 1'b1;
        if (i_req && (r_starve < STARVE_LIM)) r_starve <= r_starve + SW'(1);
      end
      if (w_grant_i) begin
        r_addr   <= i_addr & 32'hFFFF_FFFC;
        r_wr     <= 1'b0;
        r_rd     <= 1'b1;
        r_own_d  <= 1'b0;
        r_starve <= '0;
      end
      if (w_fin) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
        if (r_own_d) begin
          r_d_done <= 1'b1;
          if (!r_wr) r_d_rdata <= avm_readdata;
        end else begin
          r_i_done  <= 1'b1;
          r_i_rdata <= avm_readdata;
        end
      end else if (w_in_bus && avm_waitrequest && w_tmo) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
        if (r_own_d) begin
          r_d_done  <= 1'b1;
          r_d_rdata <= 32'hDEAD_BEEF;
        end else begin
          r_i_done  <= 1'b1;
          r_i_rdata <= 32'hDEAD_BEEF;
        end
      end
    end
  end

`ifdef AVALON_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_err;

  assign w_tmo = w_in_bus && avm_waitrequest && (r_wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_in_bus && avm_waitrequest && !w_tmo) r_wait_cnt <= r_wait_cnt + 16'd1;
      else                                        r_wait_cnt <= '0;
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // No abort path: TIMEOUT only matters when the wait counter is built
  assign w_tmo = (TIMEOUT < 0);
  assign err   = 1'b0;
`endif

  assign avm_address    = r_addr;
  assign avm_read       = r_rd;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = 4'hF;
  assign i_rdata        = r_i_rdata;
  assign i_done         = r_i_done;
  assign d_rdata        = r_d_rdata;
  assign d_done         = r_d_done;
  assign busy           = r_busy;

endmodule
